// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared widths, typedefs and bank FSM encodings for the bank arbiter
package xbar_pkg;

   // Width of an index into n items; never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int bank_w(input int outputs);
      return clog2_min1(outputs);
   endfunction

   function automatic int idx_w(input int inputs);
      return clog2_min1(inputs);
   endfunction

   localparam int DEF_INPUTS  = 4;
   localparam int DEF_OUTPUTS = 32;

   typedef logic [bank_w(DEF_OUTPUTS)-1:0] bank_t;
   typedef logic [idx_w(DEF_INPUTS)-1:0]   idx_t;

   // Bank state machine encodings (stored in the lock bit).
   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/xbar_bank_arbiter_rr_pick.sv
// rtl/xbar_bank_arbiter_rr_pick.sv - round-robin picker: first request at or after start
// Ports:
//   req       N-bit request vector
//   start     index where the search begins (wraps modulo N)
//   win_oh    one-hot winner (0 when none)
//   win_idx   winner index (0 when none)
//   win_valid some request present
module rr_pick
   import xbar_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  win_oh,
   output logic [IW-1:0] win_idx,
   output logic          win_valid
);

   logic [IW-1:0] j;

   // N is a power of two, so the IW-bit add wraps modulo N for free.
   always_comb begin
      win_oh    = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      j         = '0;
      for (int k = 0; k < N; k++) begin
         j = start + IW'(k);
         if (!win_valid && req[j]) begin
            win_valid  = 1'b1;
            win_idx    = j;
            win_oh[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xbar_bank_arbiter.sv
// rtl/xbar_bank_arbiter.sv - burst-aware round-robin arbiter for crossbar memory banks
// Ports:
//   clk, srst     clock; asynchronous active-high reset
//   req_valid     per-input beat pending
//   req_bank      per-input target bank
//   req_last      per-input end-of-burst beat
//   bank_ready    per-bank beat acceptance
//   stat_clear    synchronous clear of stall counters
//   grant         per-input ownership of its requested bank
//   grant_valid   per-bank winner present
//   grant_idx     per-bank winning input (0 when none)
//   stall_cnt     per-input saturating stalled-cycle count
module xbar_bank_arbiter
   import xbar_pkg::*;
#(
   parameter  int INPUTS      = 4,
   parameter  int OUTPUTS     = 32,
   parameter  int HOLD_MAX    = 4,
   parameter  int STALL_WIDTH = 16,
   localparam int BANK_W      = bank_w(OUTPUTS),
   localparam int IDX_W       = idx_w(INPUTS)
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic [INPUTS-1:0]      req_valid,
   input  logic [BANK_W-1:0]      req_bank [INPUTS],
   input  logic [INPUTS-1:0]      req_last,
   input  logic [OUTPUTS-1:0]     bank_ready,
   input  logic                   stat_clear,
   output logic [INPUTS-1:0]      grant,
   output logic [OUTPUTS-1:0]     grant_valid,
   output logic [IDX_W-1:0]       grant_idx [OUTPUTS],
   output logic [STALL_WIDTH-1:0] stall_cnt [INPUTS]
);

   localparam int HOLD_W = clog2_min1(HOLD_MAX);

   typedef struct packed {
      logic [IDX_W-1:0]  ptr;
      logic [0:0]        lock;
      logic [IDX_W-1:0]  owner;
      logic [HOLD_W-1:0] hold;
   } bank_state_t;

   logic [INPUTS-1:0] win_oh [OUTPUTS];

   for (genvar b = 0; b < OUTPUTS; b++) begin : g_bank
      bank_state_t       st, st_nxt;
      logic [INPUTS-1:0] cand, pick_oh;
      logic [IDX_W-1:0]  pick_idx, win_idx;
      logic              pick_valid, owner_req, win_valid, accept;
      logic [HOLD_W-1:0] eff_hold;

      always_comb begin
         cand = '0;
         for (int i = 0; i < INPUTS; i++)
            cand[i] = req_valid[i] && (req_bank[i] == BANK_W'(b));
      end

      // A locked owner that is still asking keeps the bank regardless of ptr.
      assign owner_req = (st.lock == ST_LOCKED) && cand[st.owner];

      rr_pick #(.N(INPUTS)) u_pick (
         .req       (cand),
         .start     (st.ptr),
         .win_oh    (pick_oh),
         .win_idx   (pick_idx),
         .win_valid (pick_valid)
      );

      assign win_valid      = owner_req | pick_valid;
      assign win_idx        = owner_req ? st.owner : pick_idx;
      assign win_oh[b]      = owner_req ? (INPUTS'(1) << st.owner) : pick_oh;
      assign grant_valid[b] = win_valid;
      assign grant_idx[b]   = win_idx;
      assign accept         = win_valid && bank_ready[b];

      // A winner that did not come from an ongoing lock starts a fresh burst.
      assign eff_hold = owner_req ? st.hold : '0;

      always_comb begin
         st_nxt = st;
         if (accept) begin
            if (req_last[win_idx] || eff_hold == HOLD_W'(HOLD_MAX - 1)) begin
               st_nxt.lock = ST_OPEN;
               st_nxt.ptr  = win_idx + IDX_W'(1);
               st_nxt.hold = '0;
            end else begin
               st_nxt.lock  = ST_LOCKED;
               st_nxt.owner = win_idx;
               st_nxt.hold  = eff_hold + HOLD_W'(1);
            end
         end else if (st.lock == ST_LOCKED && !owner_req) begin
            // Owner dropped or retargeted: release and skip past it.
            st_nxt.lock = ST_OPEN;
            st_nxt.ptr  = st.owner + IDX_W'(1);
            st_nxt.hold = '0;
         end
      end

      always_ff @(posedge clk or posedge srst) begin
         if (srst) st <= '0;
         else      st <= st_nxt;
      end
   end

   // Each input targets exactly one bank, so OR-ing across banks cannot collide.
   always_comb begin
      grant = '0;
      for (int b = 0; b < OUTPUTS; b++)
         grant = grant | win_oh[b];
   end

   for (genvar i = 0; i < INPUTS; i++) begin : g_stall
      logic [STALL_WIDTH-1:0] cnt;
      logic                   stalled;

      assign stalled      = req_valid[i] && !(grant[i] && bank_ready[req_bank[i]]);
      assign stall_cnt[i] = cnt;

      always_ff @(posedge clk or posedge srst) begin
         if (srst)                       cnt <= '0;
         else if (stat_clear)            cnt <= '0;
         else if (stalled && cnt != '1)  cnt <= cnt + STALL_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// tb/tb_xbar_bank_arbiter.sv - directed self-checking bench for xbar_bank_arbiter
module tb_xbar_bank_arbiter;
   import xbar_pkg::*;

   logic        clk = 1'b0;
   logic        srst;
   logic        stat_clear;
   logic [3:0]  req_valid, req_last;
   bank_t       req_bank [4];
   logic [31:0] bank_ready;

   logic [3:0]  g1, g4;
   logic [31:0] gv1, gv4;
   logic [1:0]  gi1 [32];
   logic [1:0]  gi4 [32];
   logic [3:0]  sc1 [4];
   logic [15:0] sc4 [4];

   int checks;
   int failures;

   xbar_bank_arbiter #(.INPUTS(4), .OUTPUTS(32), .HOLD_MAX(1), .STALL_WIDTH(4)) dut1 (
      .clk(clk), .srst(srst), .req_valid(req_valid), .req_bank(req_bank),
      .req_last(req_last), .bank_ready(bank_ready), .stat_clear(stat_clear),
      .grant(g1), .grant_valid(gv1), .grant_idx(gi1), .stall_cnt(sc1));

   xbar_bank_arbiter #(.INPUTS(4), .OUTPUTS(32), .HOLD_MAX(4), .STALL_WIDTH(16)) dut4 (
      .clk(clk), .srst(srst), .req_valid(req_valid), .req_bank(req_bank),
      .req_last(req_last), .bank_ready(bank_ready), .stat_clear(stat_clear),
      .grant(g4), .grant_valid(gv4), .grant_idx(gi4), .stall_cnt(sc4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req_valid  = '0;
      req_last   = '0;
      stat_clear = 1'b0;
      bank_ready = '1;
      for (int i = 0; i < 4; i++) req_bank[i] = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      srst = 1'b1;
      tick();
      srst = 1'b0;
   endtask

   int exp2 [9] = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
   int exp4 [4] = '{0, 0, 0, 1};

   initial begin
      checks   = 0;
      failures = 0;
      idle();
      srst = 1'b1;
      #2;
      chk("rst_grant1", {28'd0, g1}, 32'd0);
      chk("rst_gv1", gv1, 32'd0);
      chk("rst_grant4", {28'd0, g4}, 32'd0);
      chk("rst_gv4", gv4, 32'd0);
      chk("rst_gi4_5", {30'd0, gi4[5]}, 32'd0);
      chk("rst_sc4_0", {16'd0, sc4[0]}, 32'd0);
      tick();
      srst = 1'b0;

      // All four inputs on bank 5: per-beat rotation (HOLD_MAX=1) vs 4-beat hold.
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) req_bank[i] = 5'd5;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("rr1_idx_c%0d", k), {30'd0, gi1[5]}, k % 4);
         chk($sformatf("rr1_grant_c%0d", k), {28'd0, g1}, 32'd1 << (k % 4));
         chk($sformatf("rr4_idx_c%0d", k), {30'd0, gi4[5]}, (k < 4) ? 32'd0 : 32'd1);
         if (k == 4)
            for (int i = 0; i < 4; i++)
               chk($sformatf("rr1_stall_%0d", i), {28'd0, sc1[i]}, 32'd3);
         tick();
      end

      // Inputs 0 and 2 on bank 7, never last: 4 beats each.
      do_reset();
      req_valid   = 4'b0101;
      req_bank[0] = 5'd7;
      req_bank[2] = 5'd7;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk($sformatf("hold_idx_c%0d", k), {30'd0, gi4[7]}, exp2[k]);
         chk($sformatf("hold_grant_c%0d", k), {28'd0, g4}, (exp2[k] == 0) ? 32'h1 : 32'h4);
         tick();
      end

      // Input 1 burst ends on beat 2; pass 1 proves ptr landed on 2.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         req_valid   = 4'b1010;
         req_bank[1] = 5'd3;
         req_bank[3] = 5'd3;
         #1;
         chk($sformatf("last_b1_p%0d", pass), {30'd0, gi4[3]}, 32'd1);
         tick();
         req_last[1] = 1'b1;
         #1;
         chk($sformatf("last_b2_p%0d", pass), {30'd0, gi4[3]}, 32'd1);
         tick();
         req_last     = '0;
         req_valid[1] = 1'b0;
         if (pass == 1) begin
            req_valid[0] = 1'b1;
            req_valid[2] = 1'b1;
            req_bank[0]  = 5'd3;
            req_bank[2]  = 5'd3;
         end
         #1;
         chk($sformatf("last_next_p%0d", pass), {30'd0, gi4[3]}, (pass == 1) ? 32'd2 : 32'd3);
      end

      // Input 0 locked on bank 9 while the bank stalls for 5 cycles.
      do_reset();
      req_valid   = 4'b0011;
      req_bank[0] = 5'd9;
      req_bank[1] = 5'd9;
      #1;
      chk("stall_first_idx", {30'd0, gi4[9]}, 32'd0);
      tick();
      chk("stall_pre_sc0", {16'd0, sc4[0]}, 32'd0);
      chk("stall_pre_sc1", {16'd0, sc4[1]}, 32'd1);
      bank_ready[9] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall_hold_idx_%0d", k), {30'd0, gi4[9]}, 32'd0);
         chk($sformatf("stall_hold_grant_%0d", k), {28'd0, g4}, 32'd1);
         tick();
      end
      chk("stall_post_sc0", {16'd0, sc4[0]}, 32'd5);
      chk("stall_post_sc1", {16'd0, sc4[1]}, 32'd6);
      bank_ready[9] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("stall_resume_%0d", k), {30'd0, gi4[9]}, exp4[k]);
         tick();
      end

      // Distinct banks: everyone granted at once.
      do_reset();
      req_valid   = 4'hF;
      req_bank[0] = 5'd0;
      req_bank[1] = 5'd8;
      req_bank[2] = 5'd16;
      req_bank[3] = 5'd31;
      #1;
      chk("dist_grant4", {28'd0, g4}, 32'hF);
      chk("dist_grant1", {28'd0, g1}, 32'hF);
      chk("dist_gv4", gv4, 32'h8001_0101);
      chk("dist_idx8", {30'd0, gi4[8]}, 32'd1);
      chk("dist_idx16", {30'd0, gi4[16]}, 32'd2);
      chk("dist_idx31", {30'd0, gi4[31]}, 32'd3);
      tick();
      for (int i = 0; i < 4; i++)
         chk($sformatf("dist_stall_%0d", i), {16'd0, sc4[i]}, 32'd0);

      // Saturation, then asynchronous reset in the middle of a burst.
      do_reset();
      req_valid     = 4'b0100;
      req_bank[2]   = 5'd4;
      bank_ready[4] = 1'b0;
      repeat (18) tick();
      req_valid   = 4'b0111;
      req_bank[0] = 5'd2;
      req_bank[1] = 5'd2;
      repeat (2) tick();
      #1;
      chk("sat_sc1_2", {28'd0, sc1[2]}, 32'd15);
      chk("sat_sc4_2", {16'd0, sc4[2]}, 32'd20);
      chk("sat_sc4_1", {16'd0, sc4[1]}, 32'd2);
      chk("mid_lock_idx", {30'd0, gi4[2]}, 32'd0);
      srst = 1'b1;
      #1;
      chk("arst_sc1_2", {28'd0, sc1[2]}, 32'd0);
      chk("arst_sc4_2", {16'd0, sc4[2]}, 32'd0);
      chk("arst_sc4_1", {16'd0, sc4[1]}, 32'd0);
      req_valid = '0;
      #1;
      chk("arst_idle_g4", {28'd0, g4}, 32'd0);
      chk("arst_idle_gv4", gv4, 32'd0);
      chk("arst_idle_gv1", gv1, 32'd0);
      req_valid = 4'b0111;
      #1;
      srst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("arst_burst_%0d", k), {30'd0, gi4[2]}, (k < 4) ? 32'd0 : 32'd1);
         tick();
      end

      // stat_clear wins over a concurrent stall increment.
      do_reset();
      req_valid     = 4'b1000;
      req_bank[3]   = 5'd4;
      bank_ready[4] = 1'b0;
      repeat (10) tick();
      chk("clr_pre", {16'd0, sc4[3]}, 32'd10);
      stat_clear = 1'b1;
      tick();
      chk("clr_zero", {16'd0, sc4[3]}, 32'd0);
      stat_clear = 1'b0;
      tick();
      chk("clr_resume", {16'd0, sc4[3]}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
